// File: rtl/haraka512_round_seq.sv
// Iterative Haraka-512 sequencer: loops the 512-bit state through an external
// round function, then applies feed-forward XOR and 256-bit truncation.
module haraka512_round_seq #(
  parameter int NUM_ROUNDS = 5,
  parameter int ROUND_W    = 3,
  parameter int STATE_W    = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] msg_i,
  output logic [ROUND_W-1:0] round_o,
  output logic [STATE_W-1:0] rf_state_o,
  input  logic [STATE_W-1:0] rf_state_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [255:0]       digest_o,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_e;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  fsm_e               fsm_q,       fsm_d;
  logic [STATE_W-1:0] state_q,     state_d;
  logic [STATE_W-1:0] ff_q,        ff_d;
  logic [ROUND_W-1:0] round_q,     round_d;
  logic [255:0]       digest_q,    digest_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;

  logic [STATE_W-1:0] ff_x;
  logic [255:0]       trunc;

  // Keep the high halves of lanes 0/1 and the low halves of lanes 2/3.
  always_comb begin
    ff_x  = rf_state_i ^ ff_q;
    trunc = {ff_x[447:384], ff_x[319:256], ff_x[255:192], ff_x[127:64]};
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    ff_d        = ff_q;
    round_d     = round_q;
    digest_d    = digest_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = msg_i;
          ff_d       = msg_i;
          round_d    = '0;
          fsm_d      = S_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        state_d = rf_state_i;
        if (round_q == LAST_ROUND) begin
          digest_d    = trunc;
          round_d     = '0;
          fsm_d       = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          round_d = round_q + ROUND_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d       = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        fsm_d       = S_IDLE;
        round_d     = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with <= only, so every flop samples the
  // pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are cleared too, so a reset discards any
      // in-flight message and no stale digest is ever visible.
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      ff_q        <= '0;
      round_q     <= '0;
      digest_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      ff_q        <= ff_d;
      round_q     <= round_d;
      digest_q    <= digest_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign round_o    = round_q;
  assign rf_state_o = state_q;
  assign digest_o   = digest_q;

endmodule
